// File: rtl/afe_spi_pkg.sv
// Shared state encoding, timing helpers and default lengths for the AFE SPI engine.
package afe_spi_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_LEAD     = 3'd1;
   localparam state_t ST_SHIFT_HI = 3'd2;
   localparam state_t ST_SHIFT_LO = 3'd3;
   localparam state_t ST_LATCH    = 3'd4;
   localparam state_t ST_GAP      = 3'd5;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int lead_len(input int clk_div);
      return clk_div;
   endfunction

   // Accept-to-done distance in sysClk cycles.
   function automatic int txn_len(input int clk_div, input int word_width, input int le_cycles);
      return 1 + clk_div * (2 * word_width + 2) + le_cycles;
   endfunction

   localparam int LEAD_LEN = lead_len(4);
   localparam int TXN_LEN  = txn_len(4, 24, 4);

endpackage

// File: rtl/afe_spi_multi_if.sv
// Command/response and pin bundle for afe_spi_multi.
// AFE_SPI_READBACK_EN adds spi_sdo, rsp_data and rsp_valid.
interface afe_spi_multi_if
   import afe_spi_pkg::*;
#(
   parameter int CHANNEL_COUNT = 2,
   parameter int WORD_WIDTH    = 24,
   parameter int CH_SEL_WIDTH  = clog2_min1(CHANNEL_COUNT)
);
   logic                     cmd_valid;
   logic                     cmd_ready;
   logic [CH_SEL_WIDTH-1:0]  cmd_channel;
   logic                     cmd_broadcast;
   logic [WORD_WIDTH-1:0]    cmd_data;
   logic                     done;
   logic                     err;
   logic [CHANNEL_COUNT-1:0] spi_clk;
   logic [CHANNEL_COUNT-1:0] spi_sdi;
   logic [CHANNEL_COUNT-1:0] spi_le;
`ifdef AFE_SPI_READBACK_EN
   logic [CHANNEL_COUNT-1:0] spi_sdo;
   logic [WORD_WIDTH-1:0]    rsp_data;
   logic                     rsp_valid;

   modport master (output cmd_valid, cmd_channel, cmd_broadcast, cmd_data, spi_sdo,
                   input  cmd_ready, done, err, spi_clk, spi_sdi, spi_le, rsp_data, rsp_valid);
   modport slave  (input  cmd_valid, cmd_channel, cmd_broadcast, cmd_data, spi_sdo,
                   output cmd_ready, done, err, spi_clk, spi_sdi, spi_le, rsp_data, rsp_valid);
`else
   modport master (output cmd_valid, cmd_channel, cmd_broadcast, cmd_data,
                   input  cmd_ready, done, err, spi_clk, spi_sdi, spi_le);
   modport slave  (input  cmd_valid, cmd_channel, cmd_broadcast, cmd_data,
                   output cmd_ready, done, err, spi_clk, spi_sdi, spi_le);
`endif
endinterface

// File: rtl/afe_spi_phase_timer.sv
// Per-phase down-counter; phase_end marks the last cycle of the loaded length.
module afe_spi_phase_timer #(
   parameter int CNT_W = 3
) (
   input  logic             sysClk,
   input  logic             sysRst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             phase_end
);
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge sysClk or negedge sysRst_n) begin
      if (!sysRst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val - CNT_W'(1);
      else if (cnt != '0)
         cnt <= cnt - CNT_W'(1);
   end

   assign phase_end = (cnt == '0);

endmodule

// File: rtl/afe_spi_multi.sv
// Command-driven multi-channel AFE SPI write engine with optional broadcast.
// AFE_SPI_READBACK_EN enables sdo capture onto rsp_data/rsp_valid.
//
// state       | meaning
// ST_IDLE     | cmd_ready high, waiting for a command
// ST_LEAD     | clk low, sdi = MSB on masked channels
// ST_SHIFT_HI | clk high on masked channels (rising edge at entry)
// ST_SHIFT_LO | clk low, sdi advanced to next bit (0 after the LSB)
// ST_LATCH    | le high on masked channels
// ST_GAP      | all pins low, done on exit
module afe_spi_multi
   import afe_spi_pkg::*;
#(
   parameter int CHANNEL_COUNT = 2,
   parameter int WORD_WIDTH    = 24,
   parameter int CLK_DIV       = 4,
   parameter int LE_CYCLES     = 4,
   parameter int CH_SEL_WIDTH  = clog2_min1(CHANNEL_COUNT)
) (
   input  logic           sysClk,
   input  logic           sysRst_n,
   afe_spi_multi_if.slave bus
);
   localparam int BIT_W   = clog2_min1(WORD_WIDTH);
   localparam int TMR_MAX = (CLK_DIV > LE_CYCLES) ? CLK_DIV : LE_CYCLES;
   localparam int CNT_W   = clog2_min1(TMR_MAX + 1);

   state_t                   state, state_nxt;
   logic [WORD_WIDTH-1:0]    sr, sr_nxt;
   logic [CHANNEL_COUNT-1:0] mask, mask_nxt;
   logic [BIT_W-1:0]         bit_cnt, bit_nxt;
   logic                     inv, inv_nxt;
   logic                     accept, chan_ok, phase_end, tmr_load, txn_end;
   logic [CNT_W-1:0]         tmr_val;

   assign accept  = bus.cmd_valid && bus.cmd_ready;
   assign chan_ok = ({1'b0, bus.cmd_channel} < (CH_SEL_WIDTH+1)'(CHANNEL_COUNT));
   assign txn_end = (state == ST_GAP) && phase_end;

   always_comb begin
      state_nxt = state;
      sr_nxt    = sr;
      mask_nxt  = mask;
      bit_nxt   = bit_cnt;
      inv_nxt   = inv;
      case (state)
         ST_IDLE: if (accept) begin
            state_nxt = ST_LEAD;
            sr_nxt    = bus.cmd_data;
            bit_nxt   = BIT_W'(WORD_WIDTH - 1);
            inv_nxt   = !bus.cmd_broadcast && !chan_ok;
            if (bus.cmd_broadcast)
               mask_nxt = '1;
            else
               mask_nxt = chan_ok ? (CHANNEL_COUNT'(1) << bus.cmd_channel) : '0;
         end
         ST_LEAD:     if (phase_end) state_nxt = ST_SHIFT_HI;
         ST_SHIFT_HI: if (phase_end) begin
            state_nxt = ST_SHIFT_LO;
            sr_nxt    = sr << 1;
         end
         // the LO phase of the last bit is kept, so LATCH follows it
         ST_SHIFT_LO: if (phase_end) begin
            if (bit_cnt == '0)
               state_nxt = ST_LATCH;
            else begin
               state_nxt = ST_SHIFT_HI;
               bit_nxt   = bit_cnt - BIT_W'(1);
            end
         end
         ST_LATCH:    if (phase_end) state_nxt = ST_GAP;
         ST_GAP:      if (phase_end) state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   assign tmr_load = (state_nxt != state);
   always_comb begin
      tmr_val = CNT_W'(CLK_DIV);
      if (state_nxt == ST_LATCH)
         tmr_val = CNT_W'(LE_CYCLES);
      else if (state_nxt == ST_LEAD)
         tmr_val = CNT_W'(lead_len(CLK_DIV));
   end

   afe_spi_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .sysClk    (sysClk),
      .sysRst_n  (sysRst_n),
      .load      (tmr_load),
      .load_val  (tmr_val),
      .phase_end (phase_end)
   );

   // Pins are registered from next-state values so they line up with the state they belong to.
   always_ff @(posedge sysClk or negedge sysRst_n) begin
      if (!sysRst_n) begin
         state         <= ST_IDLE;
         sr            <= '0;
         mask          <= '0;
         bit_cnt       <= '0;
         inv           <= 1'b0;
         bus.cmd_ready <= 1'b0;
         bus.done      <= 1'b0;
         bus.err       <= 1'b0;
         bus.spi_clk   <= '0;
         bus.spi_sdi   <= '0;
         bus.spi_le    <= '0;
      end else begin
         state         <= state_nxt;
         sr            <= sr_nxt;
         mask          <= mask_nxt;
         bit_cnt       <= bit_nxt;
         inv           <= inv_nxt;
         bus.cmd_ready <= (state_nxt == ST_IDLE);
         bus.done      <= txn_end;
         bus.err       <= txn_end && inv;
         bus.spi_clk   <= (state_nxt == ST_SHIFT_HI) ? mask_nxt : '0;
         bus.spi_le    <= (state_nxt == ST_LATCH) ? mask_nxt : '0;
         bus.spi_sdi   <= ((state_nxt inside {ST_LEAD, ST_SHIFT_HI, ST_SHIFT_LO}) &&
                           sr_nxt[WORD_WIDTH-1]) ? mask_nxt : '0;
      end
   end

`ifdef AFE_SPI_READBACK_EN
   logic [CH_SEL_WIDTH-1:0] rb_ch;

   always_ff @(posedge sysClk or negedge sysRst_n) begin
      if (!sysRst_n) begin
         rb_ch         <= '0;
         bus.rsp_data  <= '0;
         bus.rsp_valid <= 1'b0;
      end else begin
         bus.rsp_valid <= txn_end;
         if (accept) begin
            rb_ch        <= (bus.cmd_broadcast || !chan_ok) ? '0 : bus.cmd_channel;
            bus.rsp_data <= '0;
         end else if ((state == ST_SHIFT_HI) && phase_end)
            bus.rsp_data <= {bus.rsp_data[WORD_WIDTH-2:0], bus.spi_sdo[rb_ch]};
      end
   end
`endif

endmodule

// File: tb/tb_afe_spi_multi.sv
// Self-checking bench for afe_spi_multi: directed table, back-to-back, mid-transaction reset, random commands.
module tb_afe_spi_multi;
   localparam int NCH    = 3;
   localparam int WW     = 24;
   localparam int CDIV   = 4;
   localparam int LEC    = 4;
   localparam int T_DONE = 1 + CDIV * (2 * WW + 2) + LEC;

   logic sysClk   = 1'b0;
   logic sysRst_n = 1'b0;

   afe_spi_multi_if #(.CHANNEL_COUNT(NCH), .WORD_WIDTH(WW), .CH_SEL_WIDTH(2)) bus ();

   afe_spi_multi #(
      .CHANNEL_COUNT (NCH),
      .WORD_WIDTH    (WW),
      .CLK_DIV       (CDIV),
      .LE_CYCLES     (LEC),
      .CH_SEL_WIDTH  (2)
   ) dut (
      .sysClk   (sysClk),
      .sysRst_n (sysRst_n),
      .bus      (bus.slave)
   );

`ifdef AFE_SPI_READBACK_EN
   assign bus.spi_sdo = bus.spi_sdi;
`endif

   always #5 sysClk = ~sysClk;

   int checks = 0;
   int passed = 0;

   typedef struct {
      logic [1:0]  ch;
      logic        bc;
      logic [23:0] data;
      logic [2:0]  exp_mask;
      logic        exp_err;
   } vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   function automatic logic [2:0] model_mask(input logic [1:0] ch, input logic bc);
      if (bc) return 3'b111;
      if (int'(ch) < NCH) return 3'(1 << ch);
      return 3'b000;
   endfunction

   task automatic drive(input logic [1:0] ch, input logic bc, input logic [23:0] data);
      bus.cmd_valid     = 1'b1;
      bus.cmd_channel   = ch;
      bus.cmd_broadcast = bc;
      bus.cmd_data      = data;
   endtask

   // Offer a command, then watch the pins until done; called and returns on a negedge.
   task automatic run_txn(input string tag, input logic [1:0] ch, input logic bc,
                          input logic [23:0] data, input logic [2:0] emask, input logic eerr,
                          input logic hold, input logic [1:0] n_ch, input logic n_bc,
                          input logic [23:0] n_data);
      int w = 0;
      int done_k = -1;
      logic err_seen = 1'b0;
      int edges [NCH];
      int hi_cnt[NCH];
      int le_cnt[NCH];
      logic act [NCH];
      logic prev[NCH];
      logic [23:0] word[NCH];
`ifdef AFE_SPI_READBACK_EN
      logic [23:0] rsp = '0;
      logic rsp_v = 1'b0;
      int rb;
`endif
      for (int c = 0; c < NCH; c++) begin
         edges[c] = 0; hi_cnt[c] = 0; le_cnt[c] = 0; act[c] = 0; prev[c] = 0; word[c] = '0;
      end
      drive(ch, bc, data);
      while (bus.cmd_ready !== 1'b1 && w < 400) begin
         @(negedge sysClk);
         w++;
      end
      if (w >= 400) begin
         check({tag, "_ready_timeout"}, 32'(bus.cmd_ready), 32'd1);
         bus.cmd_valid = 1'b0;
         return;
      end
      for (int k = 1; k <= T_DONE + 20; k++) begin
         @(negedge sysClk);
         if (k == 1) begin
            if (hold) drive(n_ch, n_bc, n_data);
            else bus.cmd_valid = 1'b0;
            check({tag, "_ready_busy"}, 32'(bus.cmd_ready), 32'd0);
         end
         for (int c = 0; c < NCH; c++) begin
            if (bus.spi_clk[c] && !prev[c]) begin
               edges[c]++;
               word[c] = {word[c][22:0], bus.spi_sdi[c]};
            end
            prev[c] = bus.spi_clk[c];
            if (bus.spi_clk[c]) hi_cnt[c]++;
            if (bus.spi_le[c])  le_cnt[c]++;
            if (bus.spi_clk[c] || bus.spi_sdi[c] || bus.spi_le[c]) act[c] = 1'b1;
         end
         if (bus.done) begin
            done_k   = k;
            err_seen = bus.err;
`ifdef AFE_SPI_READBACK_EN
            rsp   = bus.rsp_data;
            rsp_v = bus.rsp_valid;
`endif
            break;
         end
      end
      check({tag, "_done_cycle"}, 32'(done_k), 32'(T_DONE));
      check({tag, "_err"}, 32'(err_seen), 32'(eerr));
      for (int c = 0; c < NCH; c++) begin
         check($sformatf("%s_edges%0d", tag, c), 32'(edges[c]), emask[c] ? 32'(WW) : 32'd0);
         check($sformatf("%s_word%0d", tag, c), 32'(word[c]), emask[c] ? 32'(data) : 32'd0);
         check($sformatf("%s_clkhi%0d", tag, c), 32'(hi_cnt[c]), emask[c] ? 32'(WW * CDIV) : 32'd0);
         check($sformatf("%s_le%0d", tag, c), 32'(le_cnt[c]), emask[c] ? 32'(LEC) : 32'd0);
         check($sformatf("%s_act%0d", tag, c), 32'(act[c]), 32'(emask[c]));
      end
`ifdef AFE_SPI_READBACK_EN
      rb = (bc || int'(ch) >= NCH) ? 0 : int'(ch);
      check({tag, "_rsp_valid"}, 32'(rsp_v), 32'd1);
      check({tag, "_rsp_data"}, 32'(rsp), emask[rb] ? 32'(data) : 32'd0);
`endif
      if (!hold) begin
         @(negedge sysClk);
         check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
      end
   endtask

   vec_t vecs[6];

   initial begin
      int dn;
      logic [1:0] r_ch;
      logic r_bc;
      logic [23:0] r_data;

      vecs[0] = '{ch: 2'd1, bc: 1'b0, data: 24'hA5C3F0, exp_mask: 3'b010, exp_err: 1'b0};
      vecs[1] = '{ch: 2'd0, bc: 1'b1, data: 24'h000001, exp_mask: 3'b111, exp_err: 1'b0};
      vecs[2] = '{ch: 2'd3, bc: 1'b0, data: 24'h5A5A5A, exp_mask: 3'b000, exp_err: 1'b1};
      vecs[3] = '{ch: 2'd2, bc: 1'b0, data: 24'hFFFFFF, exp_mask: 3'b100, exp_err: 1'b0};
      vecs[4] = '{ch: 2'd0, bc: 1'b0, data: 24'h000000, exp_mask: 3'b001, exp_err: 1'b0};
      vecs[5] = '{ch: 2'd3, bc: 1'b1, data: 24'h800001, exp_mask: 3'b111, exp_err: 1'b0};

      bus.cmd_valid = 1'b0; bus.cmd_channel = '0; bus.cmd_broadcast = 1'b0; bus.cmd_data = '0;

      repeat (10) @(negedge sysClk);
      check("rst_pins", 32'({bus.spi_clk, bus.spi_sdi, bus.spi_le}), 32'd0);
      check("rst_ready", 32'(bus.cmd_ready), 32'd0);
      check("rst_done_err", 32'({bus.done, bus.err}), 32'd0);
      sysRst_n = 1'b1;
      #1 check("rel_ready_pre_edge", 32'(bus.cmd_ready), 32'd0);
      @(negedge sysClk);
      check("rel_ready", 32'(bus.cmd_ready), 32'd1);
      check("rel_pins", 32'({bus.spi_clk, bus.spi_sdi, bus.spi_le, bus.done, bus.err}), 32'd0);

      for (int i = 0; i < 6; i++)
         run_txn($sformatf("vec%0d", i), vecs[i].ch, vecs[i].bc, vecs[i].data,
                 vecs[i].exp_mask, vecs[i].exp_err, 1'b0, 2'd0, 1'b0, 24'h0);

      // second command held valid through the whole first transaction
      run_txn("b2b_a", 2'd1, 1'b0, 24'h123456, 3'b010, 1'b0, 1'b1, 2'd2, 1'b0, 24'hC0FFEE);
      run_txn("b2b_b", 2'd2, 1'b0, 24'hC0FFEE, 3'b100, 1'b0, 1'b0, 2'd0, 1'b0, 24'h0);

      drive(2'd0, 1'b1, 24'hFFFFFF);
      dn = 0;
      while (bus.cmd_ready !== 1'b1 && dn < 400) begin @(negedge sysClk); dn++; end
      repeat (60) @(negedge sysClk);
      bus.cmd_valid = 1'b0;
      check("mid_sdi_before_rst", 32'(bus.spi_sdi), 32'h7);
      sysRst_n = 1'b0;
      #1;
      check("mid_rst_pins", 32'({bus.spi_clk, bus.spi_sdi, bus.spi_le}), 32'd0);
      check("mid_rst_ready", 32'(bus.cmd_ready), 32'd0);
      repeat (3) @(negedge sysClk);
      sysRst_n = 1'b1;
      dn = 0;
      for (int k = 0; k < T_DONE + 30; k++) begin
         @(negedge sysClk);
         if (bus.done) dn++;
      end
      check("mid_rst_no_done", 32'(dn), 32'd0);
      run_txn("post_rst", 2'd1, 1'b0, 24'hA5C3F0, 3'b010, 1'b0, 1'b0, 2'd0, 1'b0, 24'h0);

      for (int i = 0; i < 10; i++) begin
         r_ch   = 2'($urandom_range(0, 3));
         r_bc   = ($urandom_range(0, 3) == 0);
         r_data = 24'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge sysClk);
         run_txn($sformatf("rnd%0d", i), r_ch, r_bc, r_data, model_mask(r_ch, r_bc),
                 !r_bc && (int'(r_ch) >= NCH), 1'b0, 2'd0, 1'b0, 24'h0);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
